// File: rtl/fir_pkg.sv
// Shared definitions for the FIR stage, its controller and the result streamer:
// default bus widths and the stream FSM state encoding.
package fir_pkg;

    localparam int FIR_ADDR_W = 10;
    localparam int FIR_DATA_W = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/fir_result_streamer_if.sv
// Sample-memory read port plus valid/ready byte stream used by the result streamer.
// master = streamer side, slave = memory/consumer side.
interface fir_result_streamer_if
    import fir_pkg::*;
#(
    parameter int ADDR_W = FIR_ADDR_W,
    parameter int DATA_W = FIR_DATA_W
) ();

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_rdata;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport master (
        output mem_addr, mem_rd_en, m_valid, m_data, m_last,
        input  mem_rdata, m_ready
    );

    modport slave (
        input  mem_addr, mem_rd_en, m_valid, m_data, m_last,
        output mem_rdata, m_ready
    );

endinterface

// File: rtl/stream_fifo.sv
// Small synchronous FIFO with registered storage and no fall-through; the head
// entry is presented on rdata whenever the FIFO is not empty.
module stream_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign rdata = empty ? '0 : mem_q[rd_ptr];

    // NOTE: storage has no reset; rdata is gated by empty so stale entries never reach the port.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register updates together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_result_streamer.sv
// Streams filtered FIR results from the shared sample memory onto a valid/ready byte bus.
// Optional FIR_STREAM_CHECKSUM_EN adds a 16-bit running sum of accepted beats.
module fir_result_streamer
    import fir_pkg::*;
#(
    parameter int ADDR_W     = FIR_ADDR_W,
    parameter int DATA_W     = FIR_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int MEM_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W-1:0]    sample_count,
    output logic                 busy,
    output logic                 done,
`ifdef FIR_STREAM_CHECKSUM_EN
    output logic [15:0]          checksum,
`endif
    fir_result_streamer_if.master bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]        state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] last_q;
    logic [ADDR_W-1:0] rd_idx;
    logic [ADDR_W-1:0] tx_idx;
    logic [MEM_LAT-1:0] inflight_q;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              issue;
    logic              beat;

    // A read is only issued when the FIFO is guaranteed a free slot for its data.
    assign issue = (state == ST_READ)
                && (int'(fifo_count) + $countones(inflight_q) < FIFO_DEPTH);

    assign bus.mem_rd_en = issue;
    assign bus.mem_addr  = issue ? base_q + rd_idx : '0;

    assign fifo_push   = inflight_q[MEM_LAT-1] && !fifo_full;
    assign beat        = bus.m_valid && bus.m_ready;
    assign bus.m_valid = !fifo_empty;
    assign bus.m_last  = bus.m_valid && (tx_idx == last_q);

    assign busy = (state == ST_READ) || (state == ST_DRAIN);
    assign done = (state == ST_DONE);

    stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (bus.mem_rdata),
        .pop   (beat),
        .rdata (bus.m_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            base_q     <= '0;
            last_q     <= '0;
            rd_idx     <= '0;
            tx_idx     <= '0;
            inflight_q <= '0;
        end else begin
            // Read-valid pipeline: the tail bit marks mem_rdata as this cycle's FIFO write.
            inflight_q <= MEM_LAT'({inflight_q, issue});
            if (issue) rd_idx <= rd_idx + ADDR_W'(1);
            if (beat)  tx_idx <= tx_idx + ADDR_W'(1);

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        base_q <= base_addr;
                        last_q <= sample_count - ADDR_W'(1);
                        rd_idx <= '0;
                        tx_idx <= '0;
                        state  <= (sample_count != '0) ? ST_READ : ST_DONE;
                    end
                end
                ST_READ: begin
                    if (issue && (rd_idx == last_q)) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (beat && bus.m_last) state <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FIR_STREAM_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if ((state == ST_IDLE) && start) begin
            checksum <= '0;
        end else if (beat) begin
            checksum <= checksum + 16'(bus.m_data);
        end
    end
`endif

endmodule

// File: tb/tb_fir_result_streamer.sv
// Self-checking bench for fir_result_streamer: memory model, monitor and
// scenario tasks compared against a byte-sequence reference model.
module tb_fir_result_streamer;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int MEM_LAT    = 1;
    localparam int MEM_SIZE   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] sample_count = '0;
    logic              busy;
    logic              done;
`ifdef FIR_STREAM_CHECKSUM_EN
    logic [15:0]       checksum;
`endif

    logic m_ready_drv = 1'b0;
    logic ready_level = 1'b0;
    logic rand_ready  = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_cyc = 0;

    fir_result_streamer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fir_result_streamer #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .MEM_LAT    (MEM_LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .sample_count (sample_count),
        .busy         (busy),
        .done         (done),
`ifdef FIR_STREAM_CHECKSUM_EN
        .checksum     (checksum),
`endif
        .bus          (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model with MEM_LAT cycles of read latency.
    logic [DATA_W-1:0] mem [MEM_SIZE];
    logic [DATA_W-1:0] rd_pipe [MEM_LAT];
    always @(posedge clk) begin
        for (int i = MEM_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        if (bus.mem_rd_en === 1'b1) rd_pipe[0] <= mem[bus.mem_addr];
    end
    assign bus.mem_rdata = rd_pipe[MEM_LAT-1];

    always @(posedge clk) begin
        #2;
        m_ready_drv = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
    end
    assign bus.m_ready = m_ready_drv;

    // Monitor logs
    logic [ADDR_W-1:0] rd_addr_q [$];
    int                rd_cyc_q [$];
    logic [DATA_W-1:0] beat_data_q [$];
    logic              beat_last_q [$];
    int                beat_cyc_q [$];
    int                done_cyc_q [$];
    logic [15:0]       done_csum_q [$];
    bit                valid_seen;
    bit                busy_seen;
    int                outstanding;
    bit                prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data;
    logic              prev_last;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (prev_stall) begin
                n_checks++;
                if (bus.m_valid !== 1'b1 || bus.m_data !== prev_data || bus.m_last !== prev_last) begin
                    n_errors++;
                    $display("FAIL stall_hold cyc=%0d got valid=%b data=%h last=%b expected valid=1 data=%h last=%b",
                             cyc, bus.m_valid, bus.m_data, bus.m_last, prev_data, prev_last);
                end
            end
            if (bus.mem_rd_en === 1'b1) begin
                rd_addr_q.push_back(bus.mem_addr);
                rd_cyc_q.push_back(cyc);
                outstanding++;
            end
            if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
                beat_data_q.push_back(bus.m_data);
                beat_last_q.push_back(bus.m_last);
                beat_cyc_q.push_back(cyc);
                outstanding--;
            end
            if (bus.mem_rd_en === 1'b1) begin
                n_checks++;
                if (outstanding > FIFO_DEPTH) begin
                    n_errors++;
                    $display("FAIL credit cyc=%0d got outstanding=%0d expected <= %0d", cyc, outstanding, FIFO_DEPTH);
                end
            end
            if (done === 1'b1) begin
                done_cyc_q.push_back(cyc);
`ifdef FIR_STREAM_CHECKSUM_EN
                done_csum_q.push_back(checksum);
`endif
            end
            if (bus.m_valid === 1'b1) valid_seen = 1'b1;
            if (busy === 1'b1) busy_seen = 1'b1;
            prev_stall = (bus.m_valid === 1'b1) && (bus.m_ready !== 1'b1);
            prev_data  = bus.m_data;
            prev_last  = bus.m_last;
        end
    end

    // Reference model: the i-th streamed byte is the memory word at (base+i) mod 2^ADDR_W.
    function automatic logic [DATA_W-1:0] exp_byte(int b, int i);
        return mem[(b + i) % MEM_SIZE];
    endfunction

    function automatic logic [ADDR_W-1:0] exp_addr(int b, int i);
        return ADDR_W'((b + i) % MEM_SIZE);
    endfunction

    task automatic clear_log();
        rd_addr_q.delete();
        rd_cyc_q.delete();
        beat_data_q.delete();
        beat_last_q.delete();
        beat_cyc_q.delete();
        done_cyc_q.delete();
        done_csum_q.delete();
        valid_seen  = 1'b0;
        busy_seen   = 1'b0;
        outstanding = 0;
    endtask

    task automatic do_start(input int b, input int c);
        @(posedge clk); #1;
        base_addr    = ADDR_W'(b);
        sample_count = ADDR_W'(c);
        start        = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        start_cyc = cyc - 1;
    endtask

    task automatic wait_done(input int budget, output bit got);
        int k = 0;
        while (done_cyc_q.size() == 0 && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        got = (done_cyc_q.size() != 0);
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, bus.mem_rd_en, bus.m_valid, bus.m_last, bus.mem_addr, bus.m_data} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs got busy=%b done=%b rd_en=%b valid=%b last=%b addr=%h data=%h expected all 0",
                     busy, done, bus.mem_rd_en, bus.m_valid, bus.m_last, bus.mem_addr, bus.m_data);
        end
`ifdef FIR_STREAM_CHECKSUM_EN
        n_checks++;
        if (checksum !== 16'h0) begin
            n_errors++;
            $display("FAIL reset_checksum got %h expected 0000", checksum);
        end
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, bus.mem_rd_en, bus.m_valid} !== 4'b0) begin
            n_errors++;
            $display("FAIL idle_after_reset got busy=%b done=%b rd_en=%b valid=%b expected 0",
                     busy, done, bus.mem_rd_en, bus.m_valid);
        end
    endtask

    task automatic test_basic();
        bit got;
        clear_log();
        rand_ready = 1'b0; ready_level = 1'b1;
        for (int i = 0; i < 5; i++) mem[100 + i] = DATA_W'(i + 1);
        do_start(100, 5);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_busy got %b expected 1", busy);
        end
        wait_done(40, got);
        n_checks++;
        if (!got) begin n_errors++; $display("FAIL basic_timeout got no done expected done"); end
        n_checks++;
        if (rd_addr_q.size() != 5) begin
            n_errors++;
            $display("FAIL basic_reads got %0d expected 5", rd_addr_q.size());
        end
        for (int i = 0; i < 5 && i < rd_addr_q.size(); i++) begin
            n_checks++;
            if (rd_addr_q[i] !== exp_addr(100, i) || rd_cyc_q[i] != start_cyc + 1 + i) begin
                n_errors++;
                $display("FAIL basic_read[%0d] got addr=%0d cyc=%0d expected addr=%0d cyc=%0d",
                         i, rd_addr_q[i], rd_cyc_q[i], exp_addr(100, i), start_cyc + 1 + i);
            end
        end
        n_checks++;
        if (beat_data_q.size() != 5) begin
            n_errors++;
            $display("FAIL basic_beats got %0d expected 5", beat_data_q.size());
        end
        for (int i = 0; i < 5 && i < beat_data_q.size(); i++) begin
            n_checks++;
            if (beat_data_q[i] !== DATA_W'(i + 1) || beat_last_q[i] !== (i == 4) || beat_cyc_q[i] != start_cyc + 3 + i) begin
                n_errors++;
                $display("FAIL basic_beat[%0d] got data=%h last=%b cyc=%0d expected data=%h last=%b cyc=%0d",
                         i, beat_data_q[i], beat_last_q[i], beat_cyc_q[i], DATA_W'(i + 1), (i == 4), start_cyc + 3 + i);
            end
        end
        n_checks++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != start_cyc + 8) begin
            n_errors++;
            $display("FAIL basic_done got count=%0d cyc=%0d expected count=1 cyc=%0d",
                     done_cyc_q.size(), done_cyc_q[0], start_cyc + 8);
        end
    endtask

    task automatic test_back_pressure();
        bit got;
        int early;
        clear_log();
        rand_ready = 1'b0; ready_level = 1'b0;
        for (int i = 0; i < 8; i++) mem[500 + i] = DATA_W'($urandom);
        do_start(500, 8);
        // A start pulse while busy must be ignored.
        @(posedge clk); #1;
        base_addr = '0; sample_count = ADDR_W'(2); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        ready_level = 1'b1;
        wait_done(60, got);
        n_checks++;
        if (!got) begin n_errors++; $display("FAIL bp_timeout got no done expected done"); end
        early = 0;
        foreach (rd_cyc_q[i]) if (beat_cyc_q.size() == 0 || rd_cyc_q[i] < beat_cyc_q[0]) early++;
        n_checks++;
        if (early != FIFO_DEPTH) begin
            n_errors++;
            $display("FAIL bp_reads_before_pop got %0d expected %0d", early, FIFO_DEPTH);
        end
        n_checks++;
        if (rd_addr_q.size() != 8 || beat_data_q.size() != 8 || done_cyc_q.size() != 1) begin
            n_errors++;
            $display("FAIL bp_counts got reads=%0d beats=%0d dones=%0d expected 8 8 1",
                     rd_addr_q.size(), beat_data_q.size(), done_cyc_q.size());
        end
        for (int i = 0; i < 8 && i < beat_data_q.size(); i++) begin
            n_checks++;
            if (beat_data_q[i] !== exp_byte(500, i) || beat_last_q[i] !== (i == 7)) begin
                n_errors++;
                $display("FAIL bp_beat[%0d] got data=%h last=%b expected data=%h last=%b",
                         i, beat_data_q[i], beat_last_q[i], exp_byte(500, i), (i == 7));
            end
        end
    endtask

    task automatic test_zero_count();
        bit got;
        clear_log();
        rand_ready = 1'b0; ready_level = 1'b1;
        do_start(50, 0);
        wait_done(10, got);
        n_checks++;
        if (!got || done_cyc_q[0] != start_cyc + 1 || done_cyc_q.size() != 1) begin
            n_errors++;
            $display("FAIL zero_done got count=%0d cyc=%0d expected count=1 cyc=%0d",
                     done_cyc_q.size(), done_cyc_q[0], start_cyc + 1);
        end
        n_checks++;
        if (rd_addr_q.size() != 0 || valid_seen || busy_seen) begin
            n_errors++;
            $display("FAIL zero_activity got reads=%0d valid_seen=%b busy_seen=%b expected 0 0 0",
                     rd_addr_q.size(), valid_seen, busy_seen);
        end
    endtask

    task automatic test_wrap();
        bit got;
        clear_log();
        rand_ready = 1'b0; ready_level = 1'b1;
        for (int i = 0; i < 4; i++) mem[(1022 + i) % MEM_SIZE] = DATA_W'($urandom);
        do_start(1022, 4);
        wait_done(40, got);
        n_checks++;
        if (!got || rd_addr_q.size() != 4 || beat_data_q.size() != 4) begin
            n_errors++;
            $display("FAIL wrap_counts got done=%b reads=%0d beats=%0d expected 1 4 4",
                     got, rd_addr_q.size(), beat_data_q.size());
        end
        for (int i = 0; i < 4 && i < rd_addr_q.size() && i < beat_data_q.size(); i++) begin
            n_checks++;
            if (rd_addr_q[i] !== exp_addr(1022, i) || beat_data_q[i] !== exp_byte(1022, i)) begin
                n_errors++;
                $display("FAIL wrap[%0d] got addr=%0d data=%h expected addr=%0d data=%h",
                         i, rd_addr_q[i], beat_data_q[i], exp_addr(1022, i), exp_byte(1022, i));
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        bit got;
        int k;
        clear_log();
        rand_ready = 1'b0; ready_level = 1'b1;
        for (int i = 0; i < 6; i++) mem[200 + i] = DATA_W'(8'h10 + i);
        for (int i = 0; i < 3; i++) mem[300 + i] = DATA_W'(8'hA0 + i);
        do_start(200, 6);
        k = 0;
        while (beat_data_q.size() < 2 && k < 30) begin
            @(negedge clk); #1;
            k++;
        end
        n_checks++;
        if (beat_data_q.size() < 2) begin
            n_errors++;
            $display("FAIL rst_mid_progress got beats=%0d expected >= 2", beat_data_q.size());
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, bus.mem_rd_en, bus.m_valid, bus.m_last, bus.mem_addr, bus.m_data} !== '0) begin
            n_errors++;
            $display("FAIL rst_mid_outputs got busy=%b done=%b rd_en=%b valid=%b last=%b addr=%h data=%h expected all 0",
                     busy, done, bus.mem_rd_en, bus.m_valid, bus.m_last, bus.mem_addr, bus.m_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_log();
        do_start(300, 3);
        wait_done(40, got);
        n_checks++;
        if (!got || beat_data_q.size() != 3 || rd_addr_q.size() != 3) begin
            n_errors++;
            $display("FAIL rst_mid_restart got done=%b beats=%0d reads=%0d expected 1 3 3",
                     got, beat_data_q.size(), rd_addr_q.size());
        end
        for (int i = 0; i < 3 && i < beat_data_q.size(); i++) begin
            n_checks++;
            if (beat_data_q[i] !== exp_byte(300, i) || beat_last_q[i] !== (i == 2)) begin
                n_errors++;
                $display("FAIL rst_mid_beat[%0d] got data=%h last=%b expected data=%h last=%b",
                         i, beat_data_q[i], beat_last_q[i], exp_byte(300, i), (i == 2));
            end
        end
    endtask

`ifdef FIR_STREAM_CHECKSUM_EN
    task automatic test_checksum();
        bit got;
        clear_log();
        rand_ready = 1'b0; ready_level = 1'b1;
        mem[400] = 8'hFF; mem[401] = 8'hFF; mem[402] = 8'h02;
        do_start(400, 3);
        @(posedge clk); #1;
        base_addr = '0; sample_count = ADDR_W'(5); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(40, got);
        n_checks++;
        if (!got || done_csum_q.size() != 1 || done_csum_q[0] !== 16'h0200 || beat_data_q.size() != 3) begin
            n_errors++;
            $display("FAIL checksum_done got done=%b csum=%h beats=%0d expected 1 0200 3",
                     got, done_csum_q[0], beat_data_q.size());
        end
        n_checks++;
        if (checksum !== 16'h0200) begin
            n_errors++;
            $display("FAIL checksum_hold got %h expected 0200", checksum);
        end
    endtask
`endif

    task automatic test_random();
        bit got;
        int b;
        int c;
        logic [15:0] sum;
        for (int it = 0; it < 6; it++) begin
            clear_log();
            b = $urandom_range(0, MEM_SIZE - 1);
            c = $urandom_range(1, 24);
            sum = '0;
            for (int i = 0; i < c; i++) begin
                mem[(b + i) % MEM_SIZE] = DATA_W'($urandom);
                sum = sum + 16'(exp_byte(b, i));
            end
            rand_ready = 1'b1;
            do_start(b, c);
            wait_done(600, got);
            rand_ready = 1'b0;
            n_checks++;
            if (!got || rd_addr_q.size() != c || beat_data_q.size() != c || done_cyc_q.size() != 1) begin
                n_errors++;
                $display("FAIL rand%0d_counts got done=%b reads=%0d beats=%0d dones=%0d expected 1 %0d %0d 1",
                         it, got, rd_addr_q.size(), beat_data_q.size(), done_cyc_q.size(), c, c);
            end
            for (int i = 0; i < c && i < beat_data_q.size() && i < rd_addr_q.size(); i++) begin
                n_checks++;
                if (rd_addr_q[i] !== exp_addr(b, i) || beat_data_q[i] !== exp_byte(b, i) || beat_last_q[i] !== (i == c - 1)) begin
                    n_errors++;
                    $display("FAIL rand%0d_beat[%0d] got addr=%0d data=%h last=%b expected addr=%0d data=%h last=%b",
                             it, i, rd_addr_q[i], beat_data_q[i], beat_last_q[i], exp_addr(b, i), exp_byte(b, i), (i == c - 1));
                end
            end
`ifdef FIR_STREAM_CHECKSUM_EN
            n_checks++;
            if (done_csum_q.size() != 1 || done_csum_q[0] !== sum) begin
                n_errors++;
                $display("FAIL rand%0d_checksum got %h expected %h", it, done_csum_q[0], sum);
            end
`else
            if (sum === 16'hxxxx) $display("rand%0d sum undefined", it);
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_pressure();
        test_zero_count();
        test_wrap();
        test_reset_mid_stream();
`ifdef FIR_STREAM_CHECKSUM_EN
        test_checksum();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
